flit_pkt_tracker: RTL
=====================

Name: flit_pkt_tracker

Overview:
- Pipelined flit-stream annotator placed between a link receiver and a switch/endpoint input port.
- Tracks packet boundaries independently per virtual channel, so flits of different VCs may interleave at flit granularity.
- Decodes each head flit's format, dest and length fields. Marks head/tail flits and flags malformed headers.
- Generalises the single-bit-VC flit format to NUM_VC channels and optional trailer (CRC) flits.

Parameters:
- NUM_VC, 2, number of virtual channels; VC_W = max(1, clog2(NUM_VC)).
- NODE_W, 5, width of node id / dest field.
- PKT_ID_W, 2, width of packet id field.
- TRAILER_FLITS, 0, fixed flits appended to every packet (0..3).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  input flit valid
- in_ready  out  1  tracker can accept a flit
- in_vc  in  VC_W  flit VC
- in_id  in  PKT_ID_W  packet id
- in_req  in  NODE_W  requester node id
- in_payload  in  32  flit payload word
- out_valid  out  1  annotated flit valid
- out_ready  in  1  downstream accepts
- out_vc, out_id, out_req, out_payload  out  VC_W/PKT_ID_W/NODE_W/32  registered copies of the input fields
- out_head  out  1  flit is the first flit of its packet
- out_tail  out  1  flit is the last flit of its packet
- out_fmt  out  4  format of the packet the flit belongs to
- out_dest  out  NODE_W  dest of the packet the flit belongs to
- out_err  out  1  head flit carried an unknown format (8..15) or in_vc >= NUM_VC
- err_count  out  8  saturating count of flagged flits

Behaviour:
- Reset (asynchronous, active-high): out_valid=0 and all out_* fields=0. All per-VC remaining counters, latched fmt and latched dest =0. err_count=0.
- Handshake:
  - One-stage register slice; latency 1 cycle.
  - in_ready = !out_valid || out_ready.
  - Transfer occurs when in_valid && in_ready.
  - out_* is held stable while out_valid && !out_ready.
  - in_ready is combinationally dependent on out_ready.
- Head detection: a transferred flit is a head flit iff rem[in_vc]==0.
- Head decode (payload bits):
  - fmt = [31:28]
  - dest = [27:23] (low NODE_W bits of [27:28-NODE_W] when NODE_W != 5)
  - len7 = [6:0]
  - len4 = [3:0]
- Header flits: LONG_READ(0) and LONG_WRITE(1) = 2; all others = 1.
- Data flits:
  - LONG_WRITE, MEM_RESP(2), MSG(3): len7, with len7=0 meaning 128.
  - SHORT_WRITE(6): len4, with len4=0 meaning 16.
  - LONG_READ, SWITCH_CFG(4), SHORT_READ(5): 0.
- Total flits = hdr + data + TRAILER_FLITS. The counter is 8 bits; the maximum is 2+128+3=133.
- On a head flit:
  - rem[vc] := total-1.
  - Latch fmt and dest per VC.
  - out_head=1.
  - out_tail=1 iff total==1.
- On a non-head flit:
  - rem[vc] := rem[vc]-1.
  - out_head=0.
  - out_tail=1 iff rem[vc]==1.
  - out_fmt/out_dest come from the latched per-VC values.
- Error flit (unknown format on a head, or vc out of range):
  - Treated as a 1-flit packet: out_head=out_tail=1, out_err=1, rem unchanged (stays 0).
  - err_count += 1, saturating at 255.
  - out_fmt shows the raw field.
- Only the addressed VC's counter changes on a transfer. Other VCs hold.
- Stall on the output: no counter updates without a transfer.
- Reset mid-packet clears all state. The next flit on any VC is treated as a head.

Test Plan:
- SHORT_READ head (payload 0x5xxxxxxx), TRAILER_FLITS=0 -> one output cycle later: out_head=1, out_tail=1, out_fmt=5, rem stays 0.
- LONG_WRITE, len7=3 on VC0 -> 5 flits out. Flit 0 has head=1; flit 4 has tail=1; flits 1-3 have head=tail=0; all 5 have out_fmt=1.
- Interleave VC0 MSG len7=2 with VC1 SHORT_WRITE len4=0 (17 flits), alternating flits -> tails at VC0 flit 3 and VC1 flit 17. Boundaries are independent per VC.
- Boundary length values:
  - MEM_RESP len7=0 -> 129 flits.
  - TRAILER_FLITS=2 with SWITCH_CFG -> 3 flits, tail on the 3rd.
- Head with fmt=0xA -> out_err=1, head=tail=1, err_count=1. The next flit is a head. 256 such flits -> err_count saturates at 255.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles mid-packet -> out_* stable, in_ready=0, counters frozen.
  - Assert rst mid-packet -> out_valid=0 immediately; the next flit is decoded as a head.

Source files
------------

// File: rtl/flit_pkt_tracker.sv
// rtl/flit_pkt_tracker.sv - per-VC packet boundary tracker and head-flit decoder
// One-stage register slice that annotates each flit with head/tail/format/dest.
module flit_pkt_tracker #(
    parameter int NUM_VC        = 2,
    parameter int NODE_W        = 5,
    parameter int PKT_ID_W      = 2,
    parameter int TRAILER_FLITS = 0,
    localparam int VC_W         = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [VC_W-1:0]     in_vc,
    input  logic [PKT_ID_W-1:0] in_id,
    input  logic [NODE_W-1:0]   in_req,
    input  logic [31:0]         in_payload,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [VC_W-1:0]     out_vc,
    output logic [PKT_ID_W-1:0] out_id,
    output logic [NODE_W-1:0]   out_req,
    output logic [31:0]         out_payload,
    output logic                out_head,
    output logic                out_tail,
    output logic [3:0]          out_fmt,
    output logic [NODE_W-1:0]   out_dest,
    output logic                out_err,
    output logic [7:0]          err_count
);
    localparam logic [7:0] TRL  = 8'(TRAILER_FLITS);
    localparam int         VCW1 = VC_W + 1;

    localparam logic [3:0] FMT_LONG_READ   = 4'd0;
    localparam logic [3:0] FMT_LONG_WRITE  = 4'd1;
    localparam logic [3:0] FMT_MEM_RESP    = 4'd2;
    localparam logic [3:0] FMT_MSG         = 4'd3;
    localparam logic [3:0] FMT_SHORT_WRITE = 4'd6;

    logic [7:0]        rem_q      [NUM_VC];
    logic [3:0]        fmt_lat_q  [NUM_VC];
    logic [NODE_W-1:0] dest_lat_q [NUM_VC];

    logic                out_valid_q;
    logic [VC_W-1:0]     out_vc_q;
    logic [PKT_ID_W-1:0] out_id_q;
    logic [NODE_W-1:0]   out_req_q;
    logic [31:0]         out_payload_q;
    logic                out_head_q;
    logic                out_tail_q;
    logic [3:0]          out_fmt_q;
    logic [NODE_W-1:0]   out_dest_q;
    logic                out_err_q;
    logic [7:0]          err_count_q;

    logic              xfer;
    logic              vc_oor;
    logic [VC_W-1:0]   vc_idx;
    logic [3:0]        hd_fmt;
    logic [NODE_W-1:0] hd_dest;
    logic [6:0]        hd_len7;
    logic [3:0]        hd_len4;
    logic [7:0]        hdr_n;
    logic [7:0]        data_n;
    logic [7:0]        total;
    logic [7:0]        cur_rem;
    logic              is_head;
    logic              is_err;

    logic              rem_wr;
    logic [7:0]        rem_d;
    logic              out_head_d;
    logic              out_tail_d;
    logic [3:0]        out_fmt_d;
    logic [NODE_W-1:0] out_dest_d;
    logic [7:0]        err_count_d;

    assign in_ready = !out_valid_q || out_ready;
    assign xfer     = in_valid && in_ready;

    // A VC index can only be out of range when NUM_VC is not a power of two.
    generate
        if (NUM_VC == (1 << VC_W)) begin : g_vc_full
            assign vc_oor = 1'b0;
        end else begin : g_vc_part
            assign vc_oor = ({1'b0, in_vc} >= VCW1'(NUM_VC));
        end
    endgenerate

    assign vc_idx  = vc_oor ? '0 : in_vc;
    assign hd_fmt  = in_payload[31:28];
    assign hd_dest = in_payload[27 -: NODE_W];
    assign hd_len7 = in_payload[6:0];
    assign hd_len4 = in_payload[3:0];

    always_comb begin
        hdr_n = ((hd_fmt == FMT_LONG_READ) || (hd_fmt == FMT_LONG_WRITE)) ? 8'd2 : 8'd1;
        case (hd_fmt)
            FMT_LONG_WRITE, FMT_MEM_RESP, FMT_MSG:
                data_n = (hd_len7 == 7'd0) ? 8'd128 : {1'b0, hd_len7};
            FMT_SHORT_WRITE:
                data_n = (hd_len4 == 4'd0) ? 8'd16 : {4'b0, hd_len4};
            default:
                data_n = 8'd0;
        endcase
        total = hdr_n + data_n + TRL;
    end

    assign cur_rem = rem_q[vc_idx];
    assign is_head = (cur_rem == 8'd0);
    assign is_err  = vc_oor || (is_head && hd_fmt[3]);

    always_comb begin
        rem_wr = 1'b0;
        rem_d  = cur_rem;
        if (xfer && !is_err) begin
            rem_wr = 1'b1;
            rem_d  = is_head ? (total - 8'd1) : (cur_rem - 8'd1);
        end

        out_head_d = is_err || is_head;
        if (is_err) begin
            out_tail_d = 1'b1;
        end else if (is_head) begin
            out_tail_d = (total == 8'd1);
        end else begin
            out_tail_d = (cur_rem == 8'd1);
        end
        // Error and head flits report their own raw header fields.
        out_fmt_d  = out_head_d ? hd_fmt  : fmt_lat_q[vc_idx];
        out_dest_d = out_head_d ? hd_dest : dest_lat_q[vc_idx];

        err_count_d = err_count_q;
        if (xfer && is_err && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NUM_VC; v++) begin
                rem_q[v]      <= '0;
                fmt_lat_q[v]  <= '0;
                dest_lat_q[v] <= '0;
            end
            out_valid_q   <= 1'b0;
            out_vc_q      <= '0;
            out_id_q      <= '0;
            out_req_q     <= '0;
            out_payload_q <= '0;
            out_head_q    <= 1'b0;
            out_tail_q    <= 1'b0;
            out_fmt_q     <= '0;
            out_dest_q    <= '0;
            out_err_q     <= 1'b0;
            err_count_q   <= '0;
        end else begin
            err_count_q <= err_count_d;
            if (rem_wr) begin
                rem_q[vc_idx] <= rem_d;
                if (is_head) begin
                    fmt_lat_q[vc_idx]  <= hd_fmt;
                    dest_lat_q[vc_idx] <= hd_dest;
                end
            end
            if (xfer) begin
                out_valid_q   <= 1'b1;
                out_vc_q      <= in_vc;
                out_id_q      <= in_id;
                out_req_q     <= in_req;
                out_payload_q <= in_payload;
                out_head_q    <= out_head_d;
                out_tail_q    <= out_tail_d;
                out_fmt_q     <= out_fmt_d;
                out_dest_q    <= out_dest_d;
                out_err_q     <= is_err;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_vc      = out_vc_q;
    assign out_id      = out_id_q;
    assign out_req     = out_req_q;
    assign out_payload = out_payload_q;
    assign out_head    = out_head_q;
    assign out_tail    = out_tail_q;
    assign out_fmt     = out_fmt_q;
    assign out_dest    = out_dest_q;
    assign out_err     = out_err_q;
    assign err_count   = err_count_q;

endmodule
